// File: rtl/fetch_ifid_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
interface fetch_ifid_stage_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;

    // Fetch stage issues requests and consumes responses.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    // Instruction memory answers requests.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_ifid_stage.sv
// Instruction fetch stage with IF/ID pipeline register, one-word skid buffer
// for stalls, and a drain state that retires a request abandoned by a redirect.
module fetch_ifid_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    fetch_ifid_stage_if.master  imem,
    output logic [31:0]         instructionID,
    output logic [31:0]         pcID,
    output logic                validID
);
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        FULL  = 2'd3
    } state_t;

    state_t          r_state,  w_state_nxt;
    logic [XLEN-1:0] r_pc,     w_pc_nxt;
    logic [XLEN-1:0] r_old_pc, w_old_pc_nxt;
    logic [XLEN-1:0] r_skid,   w_skid_nxt;
    logic [XLEN-1:0] r_skid_pc, w_skid_pc_nxt;
    logic [XLEN-1:0] r_instr,  w_instr_nxt;
    logic [XLEN-1:0] r_pc_id,  w_pc_id_nxt;
    logic            r_valid,  w_valid_nxt;
    logic            r_req,    w_req_nxt;
    logic [XLEN-1:0] r_addr,   w_addr_nxt;

    logic            w_ready;
    logic [XLEN-1:0] w_pc_inc;

    // A transfer completes only while a request is actually outstanding.
    assign w_ready  = r_req & imem.imem_ready;
    assign w_pc_inc = r_pc + STEP;

    // State and datapath registers; request outputs are registered from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pc      <= RESET_PC;
            r_old_pc  <= RESET_PC;
            r_skid    <= '0;
            r_skid_pc <= '0;
            r_instr   <= '0;
            r_pc_id   <= '0;
            r_valid   <= 1'b0;
            r_req     <= 1'b0;
            r_addr    <= RESET_PC;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_old_pc  <= w_old_pc_nxt;
            r_skid    <= w_skid_nxt;
            r_skid_pc <= w_skid_pc_nxt;
            r_instr   <= w_instr_nxt;
            r_pc_id   <= w_pc_id_nxt;
            r_valid   <= w_valid_nxt;
            r_req     <= w_req_nxt;
            r_addr    <= w_addr_nxt;
        end
    end

    // Next-state and datapath: redirect beats stall beats normal advance.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_old_pc_nxt  = r_old_pc;
        w_skid_nxt    = r_skid;
        w_skid_pc_nxt = r_skid_pc;
        w_instr_nxt   = r_instr;
        w_pc_id_nxt   = r_pc_id;
        w_valid_nxt   = r_valid;

        if (redirect) begin
            w_instr_nxt   = '0;
            w_valid_nxt   = 1'b0;
            w_pc_id_nxt   = '0;
            w_skid_nxt    = '0;
            w_skid_pc_nxt = '0;
            w_pc_nxt      = redirect_pc;
            // A pending request cannot be withdrawn; retire it in DRAIN.
            if (r_state == FETCH && !w_ready) begin
                w_old_pc_nxt = r_pc;
                w_state_nxt  = DRAIN;
            end else if (r_state == DRAIN && !w_ready) begin
                w_state_nxt  = DRAIN;
            end else begin
                w_state_nxt  = FETCH;
            end
        end else if (stall) begin
            unique case (r_state)
                IDLE:  w_state_nxt = FETCH;
                FETCH: begin
                    if (w_ready) begin
                        w_skid_nxt    = imem.imem_rdata;
                        w_skid_pc_nxt = w_pc_inc;
                        w_pc_nxt      = w_pc_inc;
                        w_state_nxt   = FULL;
                    end
                end
                DRAIN: begin
                    if (w_ready) begin
                        w_state_nxt = FETCH;
                    end
                end
                FULL:  w_state_nxt = FULL;
                default: w_state_nxt = IDLE;
            endcase
        end else begin
            unique case (r_state)
                FULL: begin
                    w_instr_nxt = r_skid;
                    w_pc_id_nxt = r_skid_pc;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = FETCH;
                end
                FETCH: begin
                    if (w_ready) begin
                        w_instr_nxt = imem.imem_rdata;
                        w_pc_id_nxt = w_pc_inc;
                        w_valid_nxt = 1'b1;
                        w_pc_nxt    = w_pc_inc;
                    end else begin
                        w_instr_nxt = '0;
                        w_valid_nxt = 1'b0;
                    end
                end
                DRAIN: begin
                    w_instr_nxt = '0;
                    w_valid_nxt = 1'b0;
                    if (w_ready) begin
                        w_state_nxt = FETCH;
                    end
                end
                IDLE: begin
                    w_instr_nxt = '0;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = FETCH;
                end
                default: w_state_nxt = IDLE;
            endcase
        end

        // DRAIN keeps presenting the abandoned address until it is accepted.
        w_req_nxt  = (w_state_nxt == FETCH) || (w_state_nxt == DRAIN);
        w_addr_nxt = (w_state_nxt == DRAIN) ? w_old_pc_nxt : w_pc_nxt;
    end

    assign imem.imem_req  = r_req;
    assign imem.imem_addr = r_addr;
    assign instructionID  = r_instr;
    assign pcID           = r_pc_id;
    assign validID        = r_valid;
endmodule
